// File: rtl/fp_mul_pkg.sv
// Shared definitions for the serial floating-point multiplier: FSM states,
// rounding-mode encoding and special-value bit-pattern builders.
package fp_mul_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      MUL,
      NORM,
      OUT
   } state_e;

   localparam logic RND_RNE = 1'b0;
   localparam logic RND_RTZ = 1'b1;

   // Patterns are built in a wide word; callers slice the low 1+EXP_W+FRAC_W bits.
   localparam int FP_MAX_W = 128;
   typedef logic [FP_MAX_W-1:0] fp_word_t;

   function automatic fp_word_t fp_exp_ones(input int unsigned exp_w, input int unsigned frac_w);
      fp_word_t one;
      one = fp_word_t'(1);
      return ((one << exp_w) - one) << frac_w;
   endfunction

   function automatic fp_word_t fp_qnan(input int unsigned exp_w, input int unsigned frac_w);
      fp_word_t one;
      one = fp_word_t'(1);
      return fp_exp_ones(exp_w, frac_w) | (one << (frac_w - 1));
   endfunction

   function automatic fp_word_t fp_inf(input int unsigned exp_w, input int unsigned frac_w);
      return fp_exp_ones(exp_w, frac_w);
   endfunction

   function automatic fp_word_t fp_max_finite(input int unsigned exp_w, input int unsigned frac_w);
      fp_word_t one;
      one = fp_word_t'(1);
      return (((one << exp_w) - fp_word_t'(2)) << frac_w) | ((one << frac_w) - one);
   endfunction

endpackage

// File: rtl/fp_mant_mul_iter.sv
// Iterative (FRAC_W+1)x(FRAC_W+1) shift-add significand multiplier, one
// multiplier bit per cycle; the start cycle already performs the first step.
module fp_mant_mul_iter
   import fp_mul_pkg::*;
#(
   parameter int FRAC_W = 52
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                start_i,
   input  logic [FRAC_W:0]     a_i,
   input  logic [FRAC_W:0]     b_i,
   output logic                done_o,
   output logic [2*FRAC_W+1:0] prod_o
);

   localparam int M  = FRAC_W + 1;
   localparam int CW = $clog2(FRAC_W + 1);

   logic [M-1:0]  hi_q, hi_d, lo_q, lo_d;
   logic [M-1:0]  cur_hi, cur_lo;
   logic [M:0]    sum;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          run_q, run_d;

   // a_i/b_i must stay stable from start_i until the product has been consumed.
   always_comb begin
      cur_hi = start_i ? '0 : hi_q;
      cur_lo = start_i ? b_i : lo_q;
      sum    = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, a_i} : '0);
      hi_d   = hi_q;
      lo_d   = lo_q;
      cnt_d  = cnt_q;
      run_d  = run_q;
      if (start_i) begin
         hi_d  = sum[M:1];
         lo_d  = {sum[0], cur_lo[M-1:1]};
         cnt_d = CW'(FRAC_W);
         run_d = 1'b1;
      end else if (run_q) begin
         hi_d  = sum[M:1];
         lo_d  = {sum[0], cur_lo[M-1:1]};
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            run_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         hi_q  <= '0;
         lo_q  <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

   // done_o marks the cycle of the final step; prod_o is complete from the next cycle.
   assign done_o = run_q && (cnt_q == CW'(1));
   assign prod_o = {hi_q, lo_q};

endmodule

// File: rtl/fp_mul_serial.sv
// Byte-serial IEEE-style multiplier: loads A then B LSB-beat first, multiplies
// iteratively, rounds (RNE/RTZ) and streams the result back LSB-beat first.
//
// state | meaning
// IDLE  | waiting for A beat 0
// LOAD  | collecting remaining A and B beats
// MUL   | iterative significand multiply running
// NORM  | normalise, round, handle specials, pack
// OUT   | streaming result beats, READY on beat 0
module fp_mul_serial
   import fp_mul_pkg::*;
#(
   parameter int EXP_W  = 11,
   parameter int FRAC_W = 52,
   parameter int BUS_W  = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             ENABLE,
   input  logic [BUS_W-1:0] DATA_IN,
   input  logic             RND_MODE,
   output logic [BUS_W-1:0] DATA_OUT,
   output logic             READY,
   output logic             BUSY
);

   localparam int W     = 1 + EXP_W + FRAC_W;
   localparam int BEATS = W / BUS_W;
   localparam int M     = FRAC_W + 1;
   localparam int XW    = EXP_W + 2;
   localparam int BCW   = $clog2(2 * BEATS);
   localparam int OCW   = $clog2(BEATS + 1);

   localparam fp_word_t QNAN_X = fp_qnan(EXP_W, FRAC_W);
   localparam fp_word_t INF_X  = fp_inf(EXP_W, FRAC_W);
   localparam fp_word_t MAXF_X = fp_max_finite(EXP_W, FRAC_W);
   localparam logic signed [XW-1:0] BIAS_S = XW'(2 ** (EXP_W - 1) - 1);
   localparam logic signed [XW-1:0] EMAX_S = XW'(2 ** EXP_W - 1);
   localparam logic signed [XW-1:0] ONE_S  = XW'(1);

   state_e           state_q, state_d;
   logic [BCW-1:0]   beats_q, beats_d;
   logic [2*W-1:0]   ops_q, ops_d;
   logic             rnd_q, rnd_d;
   logic             start_q, start_d;
   logic [W-1:0]     res_q, res_d;
   logic [OCW-1:0]   outs_q, outs_d;

   logic [W-1:0]     op_a, op_b;
   logic [EXP_W-1:0] ea, eb;
   logic [FRAC_W-1:0] fa, fb;
   logic             mul_done;
   logic [2*M-1:0]   prod;

   // A arrives first, so after all beats it sits in the low half.
   assign op_a = ops_q[W-1:0];
   assign op_b = ops_q[2*W-1:W];
   assign ea   = op_a[W-2:FRAC_W];
   assign eb   = op_b[W-2:FRAC_W];
   assign fa   = op_a[FRAC_W-1:0];
   assign fb   = op_b[FRAC_W-1:0];

   fp_mant_mul_iter #(
      .FRAC_W (FRAC_W)
   ) u_mant_mul (
      .clk_i   (CLK),
      .rst_ni  (RESET),
      .start_i (start_q),
      .a_i     ({1'b1, fa}),
      .b_i     ({1'b1, fb}),
      .done_o  (mul_done),
      .prod_o  (prod)
   );

   logic                 sign, msb, guard, sticky, rnd_up;
   logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic [2*M-1:0]       pn;
   logic [FRAC_W-1:0]    frac;
   logic [FRAC_W+1:0]    mant;
   logic signed [XW-1:0] exp_s;
   logic [W-1:0]         pack_res;
   logic                 unused_bits;

   always_comb begin
      sign   = op_a[W-1] ^ op_b[W-1];
      a_zero = ~|ea;
      b_zero = ~|eb;
      a_nan  = (&ea) & (|fa);
      b_nan  = (&eb) & (|fb);
      a_inf  = (&ea) & ~(|fa);
      b_inf  = (&eb) & ~(|fb);
      msb    = prod[2*M-1];
      pn     = msb ? prod : (prod << 1);
      frac   = pn[2*FRAC_W:FRAC_W+1];
      guard  = pn[FRAC_W];
      sticky = |pn[FRAC_W-1:0];
      rnd_up = (rnd_q == RND_RNE) & guard & (sticky | frac[0]);
      mant   = {2'b01, frac} + {{(FRAC_W+1){1'b0}}, rnd_up};
      exp_s  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S
             + $signed(XW'(msb)) + $signed(XW'(mant[FRAC_W+1]));
      unused_bits = pn[2*M-1] ^ mant[FRAC_W];

      if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
         pack_res = QNAN_X[W-1:0];
      end else if (a_inf || b_inf) begin
         pack_res = INF_X[W-1:0] | {sign, {(W-1){1'b0}}};
      end else if (a_zero || b_zero) begin
         pack_res = {sign, {(W-1){1'b0}}};
      end else if (exp_s >= EMAX_S) begin
         pack_res = ((rnd_q == RND_RTZ) ? MAXF_X[W-1:0] : INF_X[W-1:0]) | {sign, {(W-1){1'b0}}};
      end else if (exp_s < ONE_S) begin
         pack_res = {sign, {(W-1){1'b0}}};
      end else begin
         pack_res = {sign, exp_s[EXP_W-1:0], mant[FRAC_W-1:0]};
      end
   end

   always_comb begin
      state_d = state_q;
      beats_d = beats_q;
      ops_d   = ops_q;
      rnd_d   = rnd_q;
      start_d = 1'b0;
      res_d   = res_q;
      outs_d  = outs_q;
      unique case (state_q)
         IDLE: begin
            if (ENABLE) begin
               ops_d   = {DATA_IN, ops_q[2*W-1:BUS_W]};
               rnd_d   = RND_MODE;
               beats_d = BCW'(2 * BEATS - 1);
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (ENABLE) begin
               ops_d = {DATA_IN, ops_q[2*W-1:BUS_W]};
               if (beats_q == BCW'(1)) begin
                  beats_d = '0;
                  start_d = 1'b1;
                  state_d = MUL;
               end else begin
                  beats_d = beats_q - BCW'(1);
               end
            end
         end
         MUL: begin
            if (mul_done) begin
               state_d = NORM;
            end
         end
         NORM: begin
            res_d   = pack_res;
            outs_d  = OCW'(BEATS - 1);
            state_d = OUT;
         end
         OUT: begin
            if (outs_q == '0) begin
               state_d = IDLE;
            end else begin
               outs_d = outs_q - OCW'(1);
               res_d  = res_q >> BUS_W;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q <= IDLE;
         beats_q <= '0;
         ops_q   <= '0;
         rnd_q   <= RND_RNE;
         start_q <= 1'b0;
         res_q   <= '0;
         outs_q  <= '0;
      end else begin
         state_q <= state_d;
         beats_q <= beats_d;
         ops_q   <= ops_d;
         rnd_q   <= rnd_d;
         start_q <= start_d;
         res_q   <= res_d;
         outs_q  <= outs_d;
      end
   end

   assign DATA_OUT = (state_q == OUT) ? res_q[BUS_W-1:0] : '0;
   assign READY    = (state_q == OUT) && (outs_q == OCW'(BEATS - 1));
   assign BUSY     = (state_q != IDLE);

endmodule

// File: tb/tb_fp_mul_serial.sv
// Bench for fp_mul_serial: FP64 and FP32 instances, directed special cases,
// abort-by-reset, and random FP64 operands checked against real multiplication.
module tb_fp_mul_serial;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en64, rnd64, rdy64, busy64;
   logic [7:0] din64, dout64;
   logic       en32, rnd32, rdy32, busy32;
   logic [7:0] din32, dout32;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        rnd;
      logic [63:0] r;
   } vec_t;

   always #5 clk = ~clk;

   fp_mul_serial u_dut64 (
      .CLK      (clk),
      .RESET    (rst_n),
      .ENABLE   (en64),
      .DATA_IN  (din64),
      .RND_MODE (rnd64),
      .DATA_OUT (dout64),
      .READY    (rdy64),
      .BUSY     (busy64)
   );

   fp_mul_serial #(
      .EXP_W  (8),
      .FRAC_W (23),
      .BUS_W  (8)
   ) u_dut32 (
      .CLK      (clk),
      .RESET    (rst_n),
      .ENABLE   (en32),
      .DATA_IN  (din32),
      .RND_MODE (rnd32),
      .DATA_OUT (dout32),
      .READY    (rdy32),
      .BUSY     (busy32)
   );

   initial begin
      #900000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
      return $realtobits($bitstoreal(a) * $bitstoreal(b));
   endfunction

   task automatic send64(input logic [63:0] a, input logic [63:0] b, input logic rnd, input int gap);
      logic [127:0] ab;
      int g;
      ab = {b, a};
      for (int i = 0; i < 16; i++) begin
         en64  = 1'b1;
         din64 = ab[8*i +: 8];
         rnd64 = (i == 0) ? rnd : ~rnd;
         step();
         en64  = 1'b0;
         din64 = 8'($urandom);
         if (i != 15) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            repeat (g) step();
         end
      end
   endtask

   task automatic collect64(input bit junk, output logic [63:0] res, output int lat,
                            output int nready, output bit idle_ok);
      lat = -1; nready = 0; res = '0; idle_ok = 1'b0;
      for (int c = 1; c <= 300; c++) begin
         if (rdy64) begin
            lat = c;
            break;
         end
         if (junk) begin
            en64  = 1'($urandom);
            din64 = 8'($urandom);
         end
         step();
      end
      en64 = 1'b0;
      if (lat < 0) return;
      for (int k = 0; k < 8; k++) begin
         res[8*k +: 8] = dout64;
         nready += int'(rdy64);
         step();
      end
      idle_ok = (dout64 == 8'h00) && !rdy64 && !busy64;
   endtask

   task automatic op32(input logic [31:0] a, input logic [31:0] b, output logic [31:0] res,
                       output int lat, output int nready);
      logic [63:0] ab;
      ab = {b, a};
      lat = -1; nready = 0; res = '0;
      for (int i = 0; i < 8; i++) begin
         en32  = 1'b1;
         din32 = ab[8*i +: 8];
         rnd32 = 1'b0;
         step();
         en32  = 1'b0;
      end
      for (int c = 1; c <= 200; c++) begin
         if (rdy32) begin
            lat = c;
            break;
         end
         step();
      end
      if (lat < 0) return;
      for (int k = 0; k < 4; k++) begin
         res[8*k +: 8] = dout32;
         nready += int'(rdy32);
         step();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en64 = 1'b0; din64 = '0; rnd64 = 1'b0;
      en32 = 1'b0; din32 = '0; rnd32 = 1'b0;
      repeat (3) step();
      checks++;
      if (dout64 !== 8'h00) begin errors++; $display("FAIL reset_dout64 got %h want 00", dout64); end
      checks++;
      if (rdy64 !== 1'b0) begin errors++; $display("FAIL reset_ready64 got %b want 0", rdy64); end
      checks++;
      if (busy64 !== 1'b0) begin errors++; $display("FAIL reset_busy64 got %b want 0", busy64); end
      checks++;
      if (dout32 !== 8'h00 || rdy32 !== 1'b0 || busy32 !== 1'b0) begin
         errors++; $display("FAIL reset_dut32 got dout=%h ready=%b busy=%b want 0/0/0", dout32, rdy32, busy32);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      logic [63:0] res;
      int lat, nr;
      bit idle_ok;
      send64(64'h4000000000000000, 64'h4008000000000000, 1'b0, 0);
      checks++;
      if (busy64 !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy64); end
      collect64(1'b0, res, lat, nr, idle_ok);
      checks++;
      if (lat !== 55) begin errors++; $display("FAIL basic_latency got %0d want 55", lat); end
      checks++;
      if (res !== 64'h4018000000000000) begin errors++; $display("FAIL basic_result got %h want 4018000000000000", res); end
      checks++;
      if (nr !== 1) begin errors++; $display("FAIL basic_ready_count got %0d want 1", nr); end
      checks++;
      if (idle_ok !== 1'b1) begin errors++; $display("FAIL basic_idle_after got %b want 1", idle_ok); end
   endtask

   task automatic test_gaps();
      logic [63:0] res;
      int lat, nr;
      bit idle_ok;
      send64(64'hBFF8000000000000, 64'h3FF8000000000000, 1'b0, 3);
      collect64(1'b1, res, lat, nr, idle_ok);
      checks++;
      if (res !== 64'hC002000000000000) begin errors++; $display("FAIL gaps_result got %h want C002000000000000", res); end
      checks++;
      if (lat !== 55 || nr !== 1) begin errors++; $display("FAIL gaps_timing got lat=%0d ready=%0d want 55/1", lat, nr); end
   endtask

   task automatic test_special();
      vec_t sv [$];
      logic [63:0] res;
      int lat, nr;
      bit idle_ok;
      sv.push_back('{64'h7FF0000000000000, 64'h0000000000000000, 1'b0, 64'h7FF8000000000000});
      sv.push_back('{64'h7FF0000000000001, 64'h3FF0000000000000, 1'b0, 64'h7FF8000000000000});
      sv.push_back('{64'hBFF0000000000000, 64'hFFF8000000000123, 1'b1, 64'h7FF8000000000000});
      sv.push_back('{64'h7FF0000000000000, 64'hC000000000000000, 1'b0, 64'hFFF0000000000000});
      sv.push_back('{64'h8000000000000000, 64'h4000000000000000, 1'b0, 64'h8000000000000000});
      sv.push_back('{64'h000FFFFFFFFFFFFF, 64'h4000000000000000, 1'b0, 64'h0000000000000000});
      sv.push_back('{64'h8010000000000000, 64'h3FE0000000000000, 1'b0, 64'h8000000000000000});
      sv.push_back('{64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 1'b0, 64'h7FF0000000000000});
      sv.push_back('{64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 1'b1, 64'h7FEFFFFFFFFFFFFF});
      sv.push_back('{64'hFFEFFFFFFFFFFFFF, 64'h4000000000000000, 1'b1, 64'hFFEFFFFFFFFFFFFF});
      sv.push_back('{64'h3FF0000000000001, 64'h3FF8000000000000, 1'b0, 64'h3FF8000000000002});
      sv.push_back('{64'h3FF0000000000001, 64'h3FF8000000000000, 1'b1, 64'h3FF8000000000001});
      foreach (sv[i]) begin
         send64(sv[i].a, sv[i].b, sv[i].rnd, 0);
         collect64(1'b0, res, lat, nr, idle_ok);
         checks++;
         if (res !== sv[i].r || lat !== 55) begin
            errors++;
            $display("FAIL special_%0d got %h lat=%0d want %h lat=55", i, res, lat, sv[i].r);
         end
      end
   endtask

   task automatic test_abort();
      logic [63:0] res;
      int lat, nr, spurious;
      bit idle_ok, seen;
      send64(64'h4000000000000000, 64'h4008000000000000, 1'b0, 0);
      seen = 1'b0;
      for (int c = 1; c <= 300; c++) begin
         if (rdy64) begin
            seen = 1'b1;
            break;
         end
         step();
      end
      checks++;
      if (seen !== 1'b1) begin errors++; $display("FAIL abort_ready_seen got %b want 1", seen); end
      repeat (3) step();
      rst_n = 1'b0;
      step();
      checks++;
      if (dout64 !== 8'h00 || rdy64 !== 1'b0 || busy64 !== 1'b0) begin
         errors++; $display("FAIL abort_outputs got dout=%h ready=%b busy=%b want 0/0/0", dout64, rdy64, busy64);
      end
      rst_n = 1'b1;
      spurious = 0;
      for (int c = 0; c < 80; c++) begin
         if (rdy64 || dout64 != 8'h00) spurious++;
         step();
      end
      checks++;
      if (spurious !== 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles want 0", spurious); end
      send64(64'h4000000000000000, 64'h4008000000000000, 1'b0, 0);
      collect64(1'b0, res, lat, nr, idle_ok);
      checks++;
      if (res !== 64'h4018000000000000 || nr !== 1) begin
         errors++; $display("FAIL abort_next_op got %h ready=%0d want 4018000000000000 ready=1", res, nr);
      end
   endtask

   task automatic test_fp32();
      logic [31:0] res;
      int lat, nr;
      op32(32'h40400000, 32'h3F000000, res, lat, nr);
      checks++;
      if (res !== 32'h3FC00000) begin errors++; $display("FAIL fp32_result got %h want 3FC00000", res); end
      checks++;
      if (lat !== 26 || nr !== 1) begin errors++; $display("FAIL fp32_timing got lat=%0d ready=%0d want 26/1", lat, nr); end
   endtask

   task automatic test_random_back_to_back();
      logic [63:0] a, b, want, res, ra, rb;
      int lat, nr;
      bit idle_ok;
      for (int n = 0; n < 200; n++) begin
         ra = {$urandom(), $urandom()};
         rb = {$urandom(), $urandom()};
         a = {ra[63], 11'($urandom_range(823, 1223)), ra[51:0]};
         b = {rb[63], 11'($urandom_range(823, 1223)), rb[51:0]};
         want = ref_mul(a, b);
         send64(a, b, 1'b0, -1);
         collect64(n[0], res, lat, nr, idle_ok);
         checks++;
         if (res !== want || lat !== 55 || nr !== 1) begin
            errors++;
            $display("FAIL random_%0d a=%h b=%h got %h lat=%0d ready=%0d want %h lat=55 ready=1",
                     n, a, b, res, lat, nr, want);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_special();
      test_abort();
      test_fp32();
      test_random_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
